// File: rtl/sam_pkg.sv
// sam_pkg: shared slot boundaries, default widths and registered output record for the SAM slot sequencer
package sam_pkg;
  localparam int DEF_SLOT_W = 4;
  localparam int DEF_ROW_W = 7;
  localparam logic [3:0] VDG_FIRST = 4'd0;
  localparam logic [3:0] CPU_FIRST = 4'd8;
  localparam logic [3:0] LAST_SLOT = 4'd15;
  localparam logic [3:0] REF_STEP_SLOT = 4'd7;
  localparam logic [2:0] RAS_ON = 3'd1;
  localparam logic [2:0] RAS_OFF = 3'd7;
  localparam logic [2:0] CAS_ON = 3'd3;
  localparam logic [2:0] CAS_OFF = 3'd7;
  localparam logic [2:0] MUX_ON = 3'd2;
  localparam logic [3:0] E_RISE = 4'd8;
  localparam logic [3:0] Q_RISE = 4'd4;
  localparam logic [3:0] Q_FALL = 4'd12;
  localparam logic [3:0] E_RISE_FAST = 4'd12;
  localparam logic [3:0] Q_RISE_FAST = 4'd10;
  localparam logic [3:0] Q_FALL_FAST = 4'd14;
  typedef struct packed {
    logic e;
    logic q;
    logic ras_n;
    logic cas_n;
    logic mux;
    logic vdg_slot;
    logic refresh;
  } sam_out_t;
  localparam sam_out_t OUT_RST = '{e: 1'b0, q: 1'b0, ras_n: 1'b1, cas_n: 1'b1, mux: 1'b0, vdg_slot: 1'b0, refresh: 1'b0};
endpackage

// File: rtl/sam_slot_decode.sv
// sam_slot_decode: combinational decode of a slot number and latched modes into E/Q and DRAM strobe levels
module sam_slot_decode
  import sam_pkg::*;
(
  input  logic [DEF_SLOT_W-1:0] slot,
  input  logic                  fast_mode,
  input  logic                  refresh_mode,
  output sam_out_t              dec
);
  logic [2:0] off;
  logic vdg, ras, col;
  always_comb begin
    off = slot[2:0];
    vdg = !fast_mode && slot < CPU_FIRST;
    ras = off >= RAS_ON && off < RAS_OFF;
    // a refresh half is RAS-only: no column phase at all
    col = !(vdg && refresh_mode);
    dec.e = fast_mode ? slot >= E_RISE_FAST : slot >= E_RISE;
    dec.q = fast_mode ? (slot >= Q_RISE_FAST && slot < Q_FALL_FAST) : (slot >= Q_RISE && slot < Q_FALL);
    dec.ras_n = !ras;
    dec.cas_n = !(col && off >= CAS_ON && off < CAS_OFF);
    dec.mux = col && off >= MUX_ON && off < RAS_OFF;
    dec.vdg_slot = vdg;
    dec.refresh = vdg && refresh_mode;
  end
endmodule

// File: rtl/sam_phase_seq.sv
// sam_phase_seq: 16-slot E-cycle sequencer producing registered E/Q and DRAM RAS/CAS/mux timing.
// Define FAST_RATE_EN to honour the fast input (CPU-only 8-slot E cycle).
module sam_phase_seq
  import sam_pkg::*;
#(
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              vdg_active,
  input  logic              fast,
  output logic [SLOT_W-1:0] slot,
  output logic              e,
  output logic              q,
  output logic              ras_n,
  output logic              cas_n,
  output logic              mux,
  output logic              vdg_slot,
  output logic              refresh,
  output logic [ROW_W-1:0]  ref_row
);
  logic [SLOT_W-1:0] slot_n;
  logic ref_mode, fast_mode, ref_mode_n, fast_mode_n, wrap;
  sam_out_t dec, out_q;
`ifndef FAST_RATE_EN
  logic unused_fast;
  assign unused_fast = fast;
`endif
  always_comb begin
    wrap = slot == LAST_SLOT;
    ref_mode_n = wrap ? !vdg_active : ref_mode;
`ifdef FAST_RATE_EN
    fast_mode_n = wrap ? fast : fast_mode;
`else
    fast_mode_n = 1'b0;
`endif
    slot_n = wrap ? (fast_mode_n ? CPU_FIRST : VDG_FIRST) : slot + 1'b1;
  end
  sam_slot_decode u_dec (
    .slot(slot_n),
    .fast_mode(fast_mode_n),
    .refresh_mode(ref_mode_n),
    .dec(dec)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      slot <= '1;
      ref_mode <= 1'b0;
      fast_mode <= 1'b0;
      out_q <= OUT_RST;
      ref_row <= '0;
    end else if (tick) begin
      slot <= slot_n;
      ref_mode <= ref_mode_n;
      fast_mode <= fast_mode_n;
      out_q <= dec;
      if (slot == REF_STEP_SLOT && ref_mode && !fast_mode) ref_row <= ref_row + 1'b1;
    end
  assign {e, q, ras_n, cas_n, mux, vdg_slot, refresh} = out_q;
endmodule

// File: tb/tb_sam_phase_seq.sv
// tb_sam_phase_seq: directed table-driven bench for the SAM slot sequencer
module tb_sam_phase_seq;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, vdg_active = 1'b1, fast = 1'b0;
  logic [3:0] slot;
  logic [6:0] ref_row;
  logic e, q, ras_n, cas_n, mux, vdg_slot, refresh;
  int checks = 0, failures = 0;
  typedef struct {
    logic [3:0] slot;
    logic [6:0] o;
  } vec_t;
  vec_t nv[16];
  vec_t fv[8];
  always #5 clk = ~clk;
  sam_phase_seq dut (
    .clk(clk), .rst(rst), .tick(tick), .vdg_active(vdg_active), .fast(fast),
    .slot(slot), .e(e), .q(q), .ras_n(ras_n), .cas_n(cas_n), .mux(mux),
    .vdg_slot(vdg_slot), .refresh(refresh), .ref_row(ref_row)
  );
  function automatic logic [6:0] outs();
    return {e, q, ras_n, cas_n, mux, vdg_slot, refresh};
  endfunction
  function automatic logic [6:0] rf(logic [6:0] o);
    return {o[6:4], 1'b1, 1'b0, 1'b1, 1'b1};
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic chk_all(string name, logic [3:0] s, logic [6:0] o, logic [6:0] row);
    chk({name, ".slot"}, 32'(slot), 32'(s));
    chk({name, ".outs"}, 32'(outs()), 32'(o));
    chk({name, ".ref_row"}, 32'(ref_row), 32'(row));
  endtask
  task automatic step();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask
  initial begin
    nv[0]  = '{4'd0,  7'b0011010}; nv[1]  = '{4'd1,  7'b0001010};
    nv[2]  = '{4'd2,  7'b0001110}; nv[3]  = '{4'd3,  7'b0000110};
    nv[4]  = '{4'd4,  7'b0100110}; nv[5]  = '{4'd5,  7'b0100110};
    nv[6]  = '{4'd6,  7'b0100110}; nv[7]  = '{4'd7,  7'b0111010};
    nv[8]  = '{4'd8,  7'b1111000}; nv[9]  = '{4'd9,  7'b1101000};
    nv[10] = '{4'd10, 7'b1101100}; nv[11] = '{4'd11, 7'b1100100};
    nv[12] = '{4'd12, 7'b1000100}; nv[13] = '{4'd13, 7'b1000100};
    nv[14] = '{4'd14, 7'b1000100}; nv[15] = '{4'd15, 7'b1011000};
    fv[0] = '{4'd8,  7'b0011000}; fv[1] = '{4'd9,  7'b0001000};
    fv[2] = '{4'd10, 7'b0101100}; fv[3] = '{4'd11, 7'b0100100};
    fv[4] = '{4'd12, 7'b1100100}; fv[5] = '{4'd13, 7'b1100100};
    fv[6] = '{4'd14, 7'b1000100}; fv[7] = '{4'd15, 7'b1011000};
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    chk_all("reset", 4'd15, 7'b0011000, 7'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_all($sformatf("norm%0d", i), nv[i].slot, nv[i].o, 7'd0);
      repeat (2) @(negedge clk);
      chk_all($sformatf("hold%0d", i), nv[i].slot, nv[i].o, 7'd0);
    end
    vdg_active = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_all($sformatf("ref%0d", i), nv[i].slot, i < 8 ? rf(nv[i].o) : nv[i].o, i < 8 ? 7'd0 : 7'd1);
    end
    repeat (126 * 16) step();
    chk_all("row127", 4'd15, nv[15].o, 7'd127);
    repeat (16) step();
    chk_all("row_wrap", 4'd15, nv[15].o, 7'd0);
    vdg_active = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk_all("tog_s3", 4'd3, nv[3].o, 7'd0);
    vdg_active = 1'b0;
    for (int i = 4; i < 16; i++) begin
      step();
      chk_all($sformatf("tog%0d", i), nv[i].slot, nv[i].o, 7'd0);
    end
    step();
    chk_all("tog_next0", 4'd0, rf(nv[0].o), 7'd0);
    for (int i = 1; i < 9; i++) step();
    chk_all("tog_next8", 4'd8, nv[8].o, 7'd1);
    for (int i = 9; i < 13; i++) step();
    chk_all("pre_rst12", 4'd12, nv[12].o, 7'd1);
    #1 rst = 1'b0;
    #1 chk_all("async_rst", 4'd15, 7'b0011000, 7'd0);
    vdg_active = 1'b1;
    @(negedge clk) rst = 1'b1;
    step();
    chk_all("post_rst0", 4'd0, nv[0].o, 7'd0);
    fast = 1'b1;
    for (int i = 1; i < 16; i++) step();
    chk_all("fast_pre15", 4'd15, nv[15].o, 7'd0);
    for (int i = 0; i < 16; i++) begin
      step();
`ifdef FAST_RATE_EN
      chk_all($sformatf("fast%0d", i), fv[i % 8].slot, fv[i % 8].o, 7'd0);
`else
      chk_all($sformatf("nofast%0d", i), nv[i].slot, nv[i].o, 7'd0);
`endif
    end
    fast = 1'b0;
    step();
    chk_all("fast_exit", 4'd0, nv[0].o, 7'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
